// File: rtl/seq_multiplier_param_pkg.sv
// Shared encodings for the iterative multiplier: FSM state values and operand mode.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        DONE = ST_DONE
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/seq_multiplier_param_if.sv
// Command/result bundle of the iterative multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; op_start is only accepted in IDLE/DONE, busy/op_done report state.
// Ports: op_start, op_clear, signed_mode, multiplicand, multiplier (master -> slave);
//        result, op_done, busy (slave -> master).
interface seq_multiplier_param_if #(
    parameter int WIDTH = 64
) ();
    logic                 op_start;
    logic                 op_clear;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   result;
    logic                 op_done;
    logic                 busy;

    modport master (
        output op_start, op_clear, signed_mode, multiplicand, multiplier,
        input  result, op_done, busy
    );

    modport slave (
        input  op_start, op_clear, signed_mode, multiplicand, multiplier,
        output result, op_done, busy
    );
endinterface

// File: rtl/seq_multiplier_param_step.sv
// One multiply iteration: conditional add/sub into the upper half, then shift right by one.
// Latency: combinational.
// Backpressure: none.
// Ports: acc/mcand/qm1/mode in; acc_nxt/qm1_nxt out. acc = {partial[WIDTH:0], multiplier bits[WIDTH-1:0]}.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic             qm1,
    input  logic             mode,
    output logic [2*WIDTH:0] acc_nxt,
    output logic             qm1_nxt
);
    logic [WIDTH:0]   hi;
    logic [WIDTH:0]   mc_ext;
    logic [WIDTH:0]   hi_sum;
    logic [2*WIDTH:0] pre;

    always_comb begin
        hi     = acc[2*WIDTH:WIDTH];
        // The extra top bit keeps the partial product exact for both modes.
        mc_ext = (mode == MODE_SIGNED) ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
        hi_sum = hi;
        if (mode == MODE_UNSIGNED) begin
            if (acc[0]) begin
                hi_sum = hi + mc_ext;
            end
        end else begin
            // Booth recoding of {q0, q-1}.
            case ({acc[0], qm1})
                2'b01:   hi_sum = hi + mc_ext;
                2'b10:   hi_sum = hi - mc_ext;
                default: hi_sum = hi;
            endcase
        end
        pre     = {hi_sum, acc[WIDTH-1:0]};
        acc_nxt = (mode == MODE_SIGNED) ? {pre[2*WIDTH], pre[2*WIDTH:1]}
                                        : {1'b0, pre[2*WIDTH:1]};
        qm1_nxt = acc[0];
    end
endmodule

// File: rtl/seq_multiplier_param.sv
// Iterative WIDTH x WIDTH multiplier, unsigned shift-add or signed Booth, one bit per clock.
// Latency: WIDTH busy cycles after the start edge, result/op_done valid on the following cycle.
// Backpressure: op_start ignored while busy; op_clear aborts from any state.
// Ports: clk, reset_n (async active-low), bus (slave side of seq_multiplier_param_if).
module seq_multiplier_param
    import mult_pkg::*;
#(
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    seq_multiplier_param_if.slave  bus
);
    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand_q;
    logic               mode_q;
    logic [2*WIDTH:0]   acc;
    logic               qm1;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH:0]   acc_step;
    logic               qm1_step;
    logic               last_iter;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .mcand   (mcand_q),
        .qm1     (qm1),
        .mode    (mode_q),
        .acc_nxt (acc_step),
        .qm1_nxt (qm1_step)
    );

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.op_start) state_nxt = EXEC;
            EXEC:    if (last_iter)    state_nxt = DONE;
            DONE:    if (bus.op_start) state_nxt = EXEC;
            default: state_nxt = IDLE;
        endcase
        if (bus.op_clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            mcand_q  <= '0;
            mode_q   <= MODE_UNSIGNED;
            acc      <= '0;
            qm1      <= 1'b0;
            result_q <= '0;
        end else if (bus.op_clear) begin
            cnt      <= '0;
            acc      <= '0;
            qm1      <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.op_start) begin
                        mcand_q <= bus.multiplicand;
                        mode_q  <= bus.signed_mode;
                        // Partial-product half starts cleared; the low half carries
                        // the multiplier bits that are consumed one per shift.
                        acc     <= {{(WIDTH + 1){1'b0}}, bus.multiplier};
                        qm1     <= 1'b0;
                        cnt     <= '0;
                    end
                end
                EXEC: begin
                    acc <= acc_step;
                    qm1 <= qm1_step;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        result_q <= acc_step[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result  = result_q;
    assign bus.op_done = (state == DONE);
    assign bus.busy    = (state == EXEC);
endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
- Parametrised iterative multiplier: operand width WIDTH, unsigned or signed (two's-complement) mode chosen per operation.
- Integrates control FSM, datapath and registered output stage in one block.
- Retires one multiplier bit per clock: radix-2 shift-add for unsigned, radix-2 Booth for signed.
- Sits under the ALU/top level, driven by an op_start/op_clear command interface; reports completion via op_done.

Parameters:
- WIDTH, 64, operand width in bits (legal range 4..64); result width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- op_start  input  1  start request, sampled on clk.
- op_clear  input  1  synchronous clear/abort; highest-priority command.
- signed_mode  input  1  1 = operands signed two's-complement; 0 = unsigned. Sampled with op_start.
- multiplicand  input  WIDTH  operand A, sampled with op_start.
- multiplier  input  WIDTH  operand B, sampled with op_start.
- result  output  2*WIDTH  registered product.
- op_done  output  1  high while in DONE state.
- busy  output  1  high while in EXEC state.

Behaviour:
- States (2-bit): IDLE=2'b00, EXEC=2'b01, DONE=2'b10. 2'b11 is illegal and returns to IDLE on the next edge.
- Reset (reset_n low, asynchronous):
  - state=IDLE, result=0, op_done=0, busy=0.
  - counter, accumulator and operand registers = 0.
- op_done and busy are Moore outputs decoded from the state register only; no combinational path from any input.
- Command priority per edge: op_clear > op_start > iteration.
- IDLE:
  - op_start=1 -> latch multiplicand, multiplier and signed_mode; accumulator=0, counter=0; go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - One iteration per cycle; op_start is ignored.
  - Unsigned: if the current multiplier LSB is 1, add the multiplicand into the upper WIDTH+1 accumulator bits; then logical shift right by 1.
  - Signed (Booth): examine {q0, q_-1}. 01 -> add multiplicand; 10 -> subtract multiplicand; 00/11 -> no operation. Then arithmetic shift right by 1.
  - Accumulator is 2*WIDTH+1 bits wide, so no intermediate overflow.
  - After exactly WIDTH EXEC cycles, go to DONE and load result with the low 2*WIDTH accumulator bits on that same edge.
- Latency: op_start sampled at edge 0 -> busy high for edges 1..WIDTH -> op_done and valid result visible after edge WIDTH+1, i.e. WIDTH+1 cycles from start.
- DONE:
  - result and op_done hold indefinitely.
  - op_start=1 -> latch new operands, go to EXEC. op_done falls on that edge; result keeps the old product until the new DONE.
- op_clear=1 in any state -> next state IDLE, result=0; counter and accumulator are zeroed.
  - Mid-EXEC clear aborts the operation with no op_done pulse.
  - op_clear and op_start high together -> clear wins and the start is dropped.
- Operand inputs may change freely after the start edge; only the latched copies are used.
- Width rules:
  - Signed full-range case (-2^(WIDTH-1))^2 = 2^(2WIDTH-2) must be exact.
  - Unsigned (2^WIDTH-1)^2 must be exact.
  - No saturation and no overflow flag.
- Asynchronous reset mid-EXEC -> immediate return to the reset values above.

Decomposition:
- Package mult_pkg holds:
  - state encodings IDLE/EXEC/DONE as 2-bit localparams;
  - MODE_UNSIGNED=1'b0, MODE_SIGNED=1'b1.
- Sub-module mult_step (combinational, parametrised by WIDTH):
  - inputs: accumulator, multiplicand, q_-1 bit, mode;
  - outputs: next accumulator and next q_-1 for one add/sub-and-shift iteration.
- The top module owns the FSM, counter, operand registers and result register.

Test Plan:
- Assert reset_n=0 mid-cycle -> result=0, op_done=0, busy=0 immediately, without waiting for a clock edge.
- WIDTH=8, unsigned, 255*255 -> busy for 8 cycles, then op_done=1 and result=16'hFE01 on cycle 9; holds until the next command.
- WIDTH=8, signed:
  - -128*-128 -> result=16'h4000;
  - -3*5 -> result=16'hFFF1;
  - 127*-128 -> result=16'hC080.
- WIDTH=8: start 7*9, raise op_clear at EXEC cycle 4 -> IDLE next cycle, result=0, op_done never asserted; op_start+op_clear in the same cycle -> stays IDLE.
- WIDTH=8: in DONE with result 16'hFE01, start 2*3 unsigned -> op_done=0 next cycle, result stays 16'hFE01 during EXEC, then result=16'h0006 with op_done=1.
- WIDTH=64, unsigned all-ones*all-ones -> result=128'hFFFFFFFFFFFFFFFE0000000000000001 after 65 cycles; op_start pulses during EXEC are ignored.
